sample_page_packer: RTL and testbench

SAMPLE_PAGE_PACKER -- requirements
Module: sample_page_packer

---
 rtl/sample_page_packer_pkg.sv | 29 ++
 rtl/sample_page_packer_line_fifo.sv | 61 ++++++
 rtl/sample_page_packer.sv | 185 ++++++++++++++++++
 tb/tb_sample_page_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_page_packer_pkg.sv
// Shared definitions for the sample page packer and the readback path:
// line geometry, the queued line record and the control FSM encoding.
package sample_page_packer_pkg;

  localparam int LANES_PER_LINE   = 4;
  localparam int LINE_WIDTH       = 128;
  localparam int LINE_ADDR_WIDTH  = 27;
  localparam int LANE_INDEX_WIDTH = $clog2(LANES_PER_LINE);

  // Control FSM encoding; readback tooling decodes the debug state with this.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } packerState_t;

  // One buffered memory line: where it goes, which lanes are valid, payload.
  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0] addr;
    logic [LANES_PER_LINE-1:0]  mask;
    logic [LINE_WIDTH-1:0]      data;
  } lineEntry_t;

  // One-hot lane mask for a lane index.
  function automatic logic [LANES_PER_LINE-1:0] laneMask(input logic [LANE_INDEX_WIDTH-1:0] lane);
    return LANES_PER_LINE'(1) << lane;
  endfunction

endpackage

// File: rtl/sample_page_packer_line_fifo.sv
// Synchronous FIFO of assembled lines. The head entry is presented
// combinationally and reads as all-zero while the FIFO is empty, so no
// stale line is ever visible after reset or after the last pop.
module line_fifo
  import sample_page_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  lineEntry_t pushLine,
  input  logic       pop,
  output lineEntry_t headLine,
  output logic [CW-1:0] count,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lineEntry_t     mem [DEPTH];
  logic [PW-1:0]  headPtr;
  logic [PW-1:0]  tailPtr;
  logic           popOk;
  logic           pushOk;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign popOk  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pushOk = push && ((count != CW'(DEPTH)) || popOk);

  assign headLine = empty ? '0 : mem[headPtr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pushOk) tailPtr <= nextPtr(tailPtr);
      if (popOk)  headPtr <= nextPtr(headPtr);
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line storage; contents are don't-care until written, the empty gate hides them.
  always_ff @(posedge clk) begin
    if (pushOk) mem[tailPtr] <= pushLine;
  end

endmodule

// File: rtl/sample_page_packer.sv
// Packs 32-bit capture packets into 128-bit memory lines keyed by
// sample_number, queues completed/partial lines and hands them to memory.
//
// Memory handshake: wr_req is valid, wr_ack is ready. A line transfers on a
// rising edge where both are high. While wr_req=1 and wr_ack=0 the
// wr_data/wr_address/wr_mask outputs hold the same head line. wr_ack while
// wr_req=0 has no effect. wr_req never waits for wr_ack.
module sample_page_packer
  import sample_page_packer_pkg::*;
#(
  // Must equal LINE_WIDTH / LANES_PER_LINE (four lanes per line).
  parameter int SAMPLE_PACKET_WIDTH = 32,
  parameter int LINE_FIFO_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
  input  logic                           write_enable,
  input  logic [31:0]                    sample_number,
  input  logic                           flush,
  output logic                           pageFull,
  output logic                           wr_req,
  output logic [LINE_WIDTH-1:0]          wr_data,
  output logic [LINE_ADDR_WIDTH-1:0]     wr_address,
  output logic [LANES_PER_LINE-1:0]      wr_mask,
  input  logic                           wr_ack,
  output logic                           busy,
  output logic                           dropped,
  output logic [31:0]                    lines_written,
  output packerState_t                   debugState
);

  localparam int CountWidth = $clog2(LINE_FIFO_DEPTH + 1);
  localparam int LastLane   = LANES_PER_LINE - 1;

  packerState_t                state;
  logic                        flushPending;

  lineEntry_t                  asmLine;
  lineEntry_t                  asmNext;
  lineEntry_t                  mergedLine;
  lineEntry_t                  pushLine;
  lineEntry_t                  headLine;

  logic [LANE_INDEX_WIDTH-1:0] laneIdx;
  logic [LINE_ADDR_WIDTH-1:0]  pktAddr;
  logic [LANES_PER_LINE-1:0]   laneBit;
  logic [LINE_WIDTH-1:0]       laneData;
  logic [LINE_WIDTH-1:0]       laneField;
  logic                        addrChange;

  logic                        pushReq;
  logic                        pushAccept;
  logic                        pop;
  logic                        fifoEmpty;
  logic [CountWidth-1:0]       fifoCount;
  logic [CountWidth-1:0]       nextCount;
  logic [2:0]                  unusedSampleBits;

  // Decode where the incoming packet lands.
  assign laneIdx          = sample_number[LANE_INDEX_WIDTH-1:0];
  assign pktAddr          = sample_number[LANE_INDEX_WIDTH +: LINE_ADDR_WIDTH];
  assign unusedSampleBits = sample_number[31:29];
  assign laneBit          = laneMask(laneIdx);
  assign laneData         = LINE_WIDTH'(samplePacket) << (laneIdx * SAMPLE_PACKET_WIDTH);
  assign laneField        = LINE_WIDTH'({SAMPLE_PACKET_WIDTH{1'b1}}) << (laneIdx * SAMPLE_PACKET_WIDTH);
  assign addrChange       = (asmLine.mask != '0) && (pktAddr != asmLine.addr);

  // The assembling line with the incoming packet written into its lane.
  always_comb begin
    mergedLine      = asmLine;
    mergedLine.addr = pktAddr;
    mergedLine.mask = asmLine.mask | laneBit;
    mergedLine.data = (asmLine.data & ~laneField) | laneData;
  end

  // Decide what (if anything) is pushed this cycle and the next assembler value.
  // A line change pushes the old partial line; the new packet starts a fresh
  // line. If that fresh line already holds lane 3 it is pushed on the next
  // cycle that has no competing push.
  always_comb begin
    pushReq  = 1'b0;
    pushLine = asmLine;
    asmNext  = asmLine;
    if (write_enable) begin
      if (addrChange) begin
        pushReq      = 1'b1;
        pushLine     = asmLine;
        asmNext      = '0;
        asmNext.addr = pktAddr;
        asmNext.mask = laneBit;
        asmNext.data = laneData;
      end else if (mergedLine.mask[LastLane] || (state == FLUSH)) begin
        pushReq  = 1'b1;
        pushLine = mergedLine;
        asmNext  = '0;
      end else begin
        asmNext = mergedLine;
      end
    end else if (asmLine.mask[LastLane] || ((state == FLUSH) && (asmLine.mask != '0))) begin
      pushReq  = 1'b1;
      pushLine = asmLine;
      asmNext  = '0;
    end
  end

  assign wr_req     = !fifoEmpty;
  assign pop        = wr_req && wr_ack;
  assign pushAccept = pushReq && ((fifoCount < CountWidth'(LINE_FIFO_DEPTH)) || pop);
  assign nextCount  = fifoCount + CountWidth'(pushAccept) - CountWidth'(pop);

  line_fifo #(
    .DEPTH (LINE_FIFO_DEPTH),
    .CW    (CountWidth)
  ) u_line_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushAccept),
    .pushLine (pushLine),
    .pop      (pop),
    .headLine (headLine),
    .count    (fifoCount),
    .empty    (fifoEmpty)
  );

  assign wr_address = headLine.addr;
  assign wr_mask    = headLine.mask;
  assign wr_data    = headLine.data;
  assign debugState = state;

  // Assembler, drop flag, accepted-line counter and back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      asmLine       <= '0;
      dropped       <= 1'b0;
      lines_written <= '0;
      pageFull      <= 1'b0;
    end else begin
      asmLine  <= asmNext;
      pageFull <= (nextCount >= CountWidth'(LINE_FIFO_DEPTH - 1));
      if (pushReq && !pushAccept) dropped <= 1'b1;
      if (pop) lines_written <= lines_written + 32'd1;
    end
  end

  // Control FSM: a flush empties the assembler, then waits for the FIFO to drain.
  // A flush that collides with a packet, or arrives while busy, is remembered
  // and taken from IDLE on a later cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      flushPending <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flushPending || (flush && !write_enable)) begin
            state        <= FLUSH;
            busy         <= 1'b1;
            flushPending <= 1'b0;
          end else if (flush) begin
            flushPending <= 1'b1;
          end
        end
        FLUSH: begin
          state <= DRAIN;
          busy  <= 1'b1;
          if (flush) flushPending <= 1'b1;
        end
        DRAIN: begin
          if (fifoEmpty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          if (flush) flushPending <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_page_packer.sv
// Directed bench for sample_page_packer with an expected-line scoreboard.
module tb_sample_page_packer;
  import sample_page_packer_pkg::*;

  localparam int LW = LINE_ADDR_WIDTH + LANES_PER_LINE + LINE_WIDTH;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [31:0]                samplePacket = '0;
  logic                       write_enable = 1'b0;
  logic [31:0]                sample_number = '0;
  logic                       flush = 1'b0;
  logic                       pageFull;
  logic                       wr_req;
  logic [LINE_WIDTH-1:0]      wr_data;
  logic [LINE_ADDR_WIDTH-1:0] wr_address;
  logic [LANES_PER_LINE-1:0]  wr_mask;
  logic                       wr_ack = 1'b0;
  logic                       busy;
  logic                       dropped;
  logic [31:0]                lines_written;
  packerState_t               debugState;

  logic [LW-1:0] exp_q[$];
  int            nTests = 0;
  int            nFail  = 0;
  logic [31:0]   pk [20];

  // Clock and DUT
  always #5 clk = ~clk;

  sample_page_packer #(
    .SAMPLE_PACKET_WIDTH (32),
    .LINE_FIFO_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .samplePacket  (samplePacket),
    .write_enable  (write_enable),
    .sample_number (sample_number),
    .flush         (flush),
    .pageFull      (pageFull),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_address    (wr_address),
    .wr_mask       (wr_mask),
    .wr_ack        (wr_ack),
    .busy          (busy),
    .dropped       (dropped),
    .lines_written (lines_written),
    .debugState    (debugState)
  );

  function automatic logic [LW-1:0] mkLine(input logic [26:0] a, input logic [3:0] m,
                                           input logic [31:0] d3, input logic [31:0] d2,
                                           input logic [31:0] d1, input logic [31:0] d0);
    return {a, m, d3, d2, d1, d0};
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] sn, input logic [31:0] pkt, input logic f);
    sample_number = sn;
    samplePacket  = pkt;
    write_enable  = 1'b1;
    flush         = f;
    tick();
    write_enable  = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic flushPulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && (wr_req || exp_q.size() != 0); i++) tick();
    check("drain_timeout", {wr_req, 31'(exp_q.size())}, 32'd0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200 && busy; i++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  // Scoreboard: every accepted line must match the next expected line.
  always @(negedge clk) begin
    if (!reset && wr_req && wr_ack) begin
      nTests++;
      assert (exp_q.size() != 0) else begin
        nFail++;
        $error("FAIL unexpected_line: observed %0h expected none", {wr_address, wr_mask, wr_data});
      end
      if (exp_q.size() != 0) check("line", {wr_address, wr_mask, wr_data}, exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_address", wr_address, '0);
    check("rst_wr_mask", wr_mask, '0);
    check("rst_pageFull", pageFull, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dropped", dropped, 1'b0);
    check("rst_lines_written", lines_written, 32'd0);
    check("rst_state", debugState, IDLE);
    reset = 1'b0;
    tick();

    // Full line at address 0
    wr_ack = 1'b1;
    exp_q.push_back(mkLine(27'd0, 4'b1111, 32'hA3, 32'hA2, 32'hA1, 32'hA0));
    for (int i = 0; i < 4; i++) send(i, 32'hA0 + i, 1'b0);
    waitDrain();
    check("lw_after_full", lines_written, 32'd1);

    // Partial line pushed by an address change, new line flushed afterwards
    exp_q.push_back(mkLine(27'd1, 4'b0110, 32'h0, 32'hB6, 32'hB5, 32'h0));
    send(5, 32'hB5, 1'b0);
    send(6, 32'hB6, 1'b0);
    send(12, 32'hBC, 1'b0);
    waitDrain();
    check("lw_after_partial", lines_written, 32'd2);
    exp_q.push_back(mkLine(27'd3, 4'b0001, 32'h0, 32'h0, 32'h0, 32'hBC));
    flushPulse();
    waitDrain();
    waitIdle();
    check("lw_after_flush_a", lines_written, 32'd3);

    // Flush of a two-lane line, busy timing
    exp_q.push_back(mkLine(27'd2, 4'b0011, 32'h0, 32'h0, 32'hC9, 32'hC8));
    send(8, 32'hC8, 1'b0);
    send(9, 32'hC9, 1'b0);
    flushPulse();
    check("flush_busy", busy, 1'b1);
    for (int i = 0; i < 20 && !wr_req; i++) tick();
    check("flush_wr_req", wr_req, 1'b1);
    for (int i = 0; i < 20 && wr_req; i++) tick();
    check("flush_busy_at_empty", {wr_req, busy}, 2'b01);
    tick();
    check("flush_busy_fall", busy, 1'b0);
    check("lw_after_flush_b", lines_written, 32'd4);

    // Flush coincident with lane 3: one full line, no extra from the deferred flush
    exp_q.push_back(mkLine(27'd4, 4'b1111, 32'hD3, 32'hD2, 32'hD1, 32'hD0));
    send(16, 32'hD0, 1'b0);
    send(17, 32'hD1, 1'b0);
    send(18, 32'hD2, 1'b0);
    send(19, 32'hD3, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    waitIdle();
    waitDrain();
    check("lw_after_coincident", lines_written, 32'd5);
    check("no_drop_yet", dropped, 1'b0);

    // Overflow: memory stalled, five lines, fifth dropped
    wr_ack = 1'b0;
    for (int i = 0; i < 20; i++) pk[i] = $urandom;
    for (int l = 0; l < 4; l++)
      exp_q.push_back(mkLine(27'(5 + l), 4'b1111, pk[4*l+3], pk[4*l+2], pk[4*l+1], pk[4*l]));
    for (int i = 0; i < 20; i++) begin
      send(20 + i, pk[i], 1'b0);
      if (i == 7)  check("pageFull_2lines", pageFull, 1'b0);
      if (i == 11) check("pageFull_3lines", pageFull, 1'b1);
      if (i == 15) check("dropped_4lines", dropped, 1'b0);
    end
    check("dropped_5th", dropped, 1'b1);
    check("stall_head", {wr_address, wr_mask, wr_data}, exp_q[0]);
    tick();
    tick();
    check("stall_hold", {wr_address, wr_mask, wr_data}, exp_q[0]);
    wr_ack = 1'b1;
    waitDrain();
    check("lw_after_overflow", lines_written, 32'd9);
    check("pageFull_drained", pageFull, 1'b0);
    check("dropped_sticky", dropped, 1'b1);

    // Reset mid-operation with two lines queued and a partial line assembling
    wr_ack = 1'b0;
    for (int i = 0; i < 9; i++) send(40 + i, $urandom, 1'b0);
    check("pre_reset_wr_req", wr_req, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_wr_req", wr_req, 1'b0);
    check("mid_rst_lines_written", lines_written, 32'd0);
    check("mid_rst_dropped", dropped, 1'b0);
    check("mid_rst_wr_data", wr_data, '0);
    reset = 1'b0;
    wr_ack = 1'b1;
    exp_q.push_back(mkLine(27'd13, 4'b1111, 32'hE3, 32'hE2, 32'hE1, 32'hE0));
    for (int i = 0; i < 4; i++) send(52 + i, 32'hE0 + i, 1'b0);
    waitDrain();
    for (int i = 0; i < 5; i++) tick();
    check("lw_after_reset", lines_written, 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
